// File: rtl/arm_cache_controller.sv
// 2-way set-associative, write-through, no-write-allocate read cache in front of the SRAM controller.
// Latency: read hits return data in the request cycle; misses and writes complete in the sram_ready cycle.
// Backpressure: ready=0 freezes the MEM stage until the SRAM transaction finishes; SRAM enables are held through sram_ready.
//
// Ports: clk/rst (async, active-high); MEM side: address, wdata, mem_r_en, mem_w_en -> rdata, ready;
// SRAM side: sram_address, sram_wdata, sram_rd_en, sram_wr_en -> sram_rdata ({word1, word0}), sram_ready.
module arm_cache_controller #(
    parameter int BASE_ADDR = 1024,
    parameter int SETS      = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    input  logic        mem_r_en,
    input  logic        mem_w_en,
    output logic [31:0] rdata,
    output logic        ready,
    output logic [31:0] sram_address,
    output logic [31:0] sram_wdata,
    output logic        sram_rd_en,
    output logic        sram_wr_en,
    input  logic [63:0] sram_rdata,
    input  logic        sram_ready
);

    typedef enum logic [1:0] {IDLE, RD_MISS, WRITE} state_t;

    state_t state_q, state_d;

    logic [SETS-1:0] valid0_q, valid0_d;
    logic [SETS-1:0] valid1_q, valid1_d;
    logic [SETS-1:0] lru_q, lru_d;        // 1 bit per set: the least-recently-used way
    logic [9:0]      tag0_q  [SETS];
    logic [9:0]      tag1_q  [SETS];
    logic [63:0]     data0_q [SETS];
    logic [63:0]     data1_q [SETS];

    // Decode on the base-relative address.
    logic [31:0] addr_off;
    logic        word_sel;
    logic [5:0]  idx;
    logic [9:0]  tag;
    logic        unused_addr_bits;

    assign addr_off         = address - 32'(BASE_ADDR);
    assign word_sel         = addr_off[2];
    assign idx              = addr_off[8:3];
    assign tag              = addr_off[18:9];
    assign unused_addr_bits = ^{addr_off[31:19], addr_off[1:0]};

    logic        hit0, hit1, hit, hit_way, victim_way;
    logic [63:0] hit_blk, merged_blk;

    assign hit0       = valid0_q[idx] && (tag0_q[idx] == tag);
    assign hit1       = valid1_q[idx] && (tag1_q[idx] == tag);
    assign hit        = hit0 || hit1;
    assign hit_way    = hit1;                 // ways never share a tag, so at most one hits
    assign hit_blk    = hit_way ? data1_q[idx] : data0_q[idx];
    assign merged_blk = word_sel ? {wdata, hit_blk[31:0]} : {hit_blk[63:32], wdata};
    // Fill an empty way first (way 0 before way 1), otherwise evict the LRU way.
    assign victim_way = !valid0_q[idx] ? 1'b0 : (!valid1_q[idx] ? 1'b1 : lru_q[idx]);

    // The MEM stage holds address/data while frozen, so a straight pass-through is stable.
    assign sram_address = address;
    assign sram_wdata   = wdata;

    logic fill_en, wr_hit_en;

    always_comb begin
        state_d    = state_q;
        valid0_d   = valid0_q;
        valid1_d   = valid1_q;
        lru_d      = lru_q;
        ready      = 1'b1;
        rdata      = 32'h0;
        sram_rd_en = 1'b0;
        sram_wr_en = 1'b0;
        fill_en    = 1'b0;
        wr_hit_en  = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_w_en) begin
                    state_d = WRITE;
                    ready   = 1'b0;
                end else if (mem_r_en) begin
                    if (hit) begin
                        rdata      = word_sel ? hit_blk[63:32] : hit_blk[31:0];
                        lru_d[idx] = ~hit_way;
                    end else begin
                        state_d = RD_MISS;
                        ready   = 1'b0;
                    end
                end
            end
            RD_MISS: begin
                sram_rd_en = 1'b1;
                ready      = 1'b0;
                if (sram_ready) begin
                    rdata      = word_sel ? sram_rdata[63:32] : sram_rdata[31:0];
                    ready      = 1'b1;
                    fill_en    = 1'b1;
                    lru_d[idx] = ~victim_way;
                    if (victim_way) valid1_d[idx] = 1'b1;
                    else            valid0_d[idx] = 1'b1;
                    state_d    = IDLE;
                end
            end
            WRITE: begin
                sram_wr_en = 1'b1;
                ready      = 1'b0;
                if (sram_ready) begin
                    ready   = 1'b1;
                    state_d = IDLE;
                    if (hit) begin
                        wr_hit_en  = 1'b1;
                        lru_d[idx] = ~hit_way;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Reset forces the idle view immediately, even mid-transaction.
        if (rst) begin
            ready      = 1'b1;
            rdata      = 32'h0;
            sram_rd_en = 1'b0;
            sram_wr_en = 1'b0;
            fill_en    = 1'b0;
            wr_hit_en  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            valid0_q <= '0;
            valid1_q <= '0;
            lru_q    <= '0;
        end else begin
            state_q  <= state_d;
            valid0_q <= valid0_d;
            valid1_q <= valid1_d;
            lru_q    <= lru_d;
        end
    end

    // Tag/data arrays need no reset: valid bits qualify every entry.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            if (victim_way) begin
                tag1_q[idx]  <= tag;
                data1_q[idx] <= sram_rdata;
            end else begin
                tag0_q[idx]  <= tag;
                data0_q[idx] <= sram_rdata;
            end
        end else if (wr_hit_en) begin
            if (hit_way) data1_q[idx] <= merged_blk;
            else         data0_q[idx] <= merged_blk;
        end
    end

endmodule

// File: tb/tb_arm_cache_controller.sv
// Testbench for arm_cache_controller: SRAM behavioural model with variable latency,
// reference cache model kept as an MRU/LRU tag list per set, expected memory image.
// Stimulus driven 1 time unit after posedge; outputs sampled on negedge.
module tb_arm_cache_controller;

    logic        clk, rst;
    logic [31:0] address, wdata, rdata, sram_address, sram_wdata;
    logic        mem_r_en, mem_w_en, ready, sram_rd_en, sram_wr_en, sram_ready;
    logic [63:0] sram_rdata;

    int checks   = 0;
    int failures = 0;
    int sram_lat = 0;     // < 0 selects a random latency per transaction

    arm_cache_controller #(.BASE_ADDR(1024), .SETS(64)) dut (
        .clk(clk), .rst(rst), .address(address), .wdata(wdata),
        .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .rdata(rdata), .ready(ready),
        .sram_address(sram_address), .sram_wdata(sram_wdata),
        .sram_rd_en(sram_rd_en), .sram_wr_en(sram_wr_en),
        .sram_rdata(sram_rdata), .sram_ready(sram_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- memories (keyed by word address) ----------------
    logic [31:0] sram_mem [int unsigned];
    logic [31:0] ref_mem  [int unsigned];

    function automatic logic [31:0] dflt(input int unsigned k);
        return 32'(k * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction
    function automatic logic [31:0] sram_word(input int unsigned k);
        return sram_mem.exists(k) ? sram_mem[k] : dflt(k);
    endfunction
    function automatic logic [31:0] ref_word(input int unsigned k);
        return ref_mem.exists(k) ? ref_mem[k] : dflt(k);
    endfunction

    // SRAM controller model: sees a request, waits, then one sram_ready pulse.
    initial begin
        int lat;
        int unsigned blk;
        sram_ready = 1'b0;
        sram_rdata = 64'h0;
        forever begin
            @(negedge clk);
            if (!rst && (sram_rd_en || sram_wr_en)) begin
                lat = (sram_lat >= 0) ? sram_lat : int'($urandom_range(0, 3));
                repeat (lat) @(negedge clk);
                @(posedge clk);
                #1;
                if (!rst && (sram_rd_en || sram_wr_en)) begin
                    if (sram_wr_en) begin
                        sram_mem[sram_address >> 2] = sram_wdata;
                    end else begin
                        blk = (sram_address >> 3) << 1;
                        sram_rdata = {sram_word(blk + 1), sram_word(blk)};
                    end
                    sram_ready = 1'b1;
                    @(posedge clk);
                    #1;
                    sram_ready = 1'b0;
                end
            end
        end
    end

    // ---------------- reference cache: per set, ordered list of up to 2 tags ----------------
    int          m_cnt [64];
    int unsigned m_mru [64];
    int unsigned m_lru [64];

    function automatic int unsigned set_of(input logic [31:0] a);
        return ((a - 32'd1024) >> 3) % 64;
    endfunction
    function automatic int unsigned tag_of(input logic [31:0] a);
        return ((a - 32'd1024) >> 9) % 1024;
    endfunction
    function automatic bit m_hit(input logic [31:0] a);
        int unsigned s = set_of(a);
        int unsigned t = tag_of(a);
        return (m_cnt[s] >= 1 && m_mru[s] == t) || (m_cnt[s] == 2 && m_lru[s] == t);
    endfunction
    function automatic void m_touch(input logic [31:0] a);
        int unsigned s = set_of(a);
        if (m_mru[s] != tag_of(a)) begin
            m_lru[s] = m_mru[s];
            m_mru[s] = tag_of(a);
        end
    endfunction
    function automatic void m_insert(input logic [31:0] a);
        int unsigned s = set_of(a);
        if (m_cnt[s] > 0) m_lru[s] = m_mru[s];   // with 2 entries the old LRU drops out
        m_mru[s] = tag_of(a);
        if (m_cnt[s] < 2) m_cnt[s]++;
    endfunction
    function automatic void m_reset();
        for (int i = 0; i < 64; i++) m_cnt[i] = 0;
    endfunction

    // ---------------- transaction driver ----------------
    task automatic do_access(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                             output int waits, output logic [31:0] got, output bit saw_rd, output bit saw_wr);
        mem_r_en = rd; mem_w_en = wr; address = a; wdata = wd;
        waits = 0; got = 32'h0; saw_rd = 1'b0; saw_wr = 1'b0;
        forever begin
            @(negedge clk);
            if (sram_rd_en) saw_rd = 1'b1;
            if (sram_wr_en) saw_wr = 1'b1;
            checks++;
            if (sram_rd_en && sram_wr_en) begin
                failures++; $display("FAIL both_enables addr=%h rd_en=%b wr_en=%b required not both", a, sram_rd_en, sram_wr_en);
            end
            checks++;
            if (sram_address !== a || (wr && sram_wdata !== wd)) begin
                failures++; $display("FAIL sram_passthru addr got=%h exp=%h wdata got=%h exp=%h", sram_address, a, sram_wdata, wd);
            end
            if (ready) begin
                got = rdata;
                break;
            end
            waits++;
            if (waits > 40) begin
                checks++; failures++;
                $display("FAIL timeout addr=%h ready stayed 0 for %0d cycles", a, waits);
                break;
            end
        end
        @(posedge clk); #1;
        mem_r_en = 1'b0; mem_w_en = 1'b0;
        @(negedge clk);
        checks++;
        if (sram_rd_en !== 1'b0 || sram_wr_en !== 1'b0 || ready !== 1'b1 || rdata !== 32'h0) begin
            failures++;
            $display("FAIL idle_after addr=%h rd_en=%b wr_en=%b ready=%b rdata=%h required 0,0,1,0", a, sram_rd_en, sram_wr_en, ready, rdata);
        end
        @(posedge clk); #1;
    endtask

    task automatic load_and_check(input logic [31:0] a, output logic [31:0] got, output bit hit);
        bit exp_hit, srd, swr;
        logic [31:0] exp_d;
        int waits;
        exp_hit = m_hit(a);
        exp_d   = ref_word(a >> 2);
        do_access(1'b1, 1'b0, a, 32'h0, waits, got, srd, swr);
        hit = (waits == 0);
        checks++;
        if (hit !== exp_hit) begin
            failures++; $display("FAIL load_hit addr=%h hit=%b required=%b waits=%0d", a, hit, exp_hit, waits);
        end
        checks++;
        if (got !== exp_d) begin
            failures++; $display("FAIL load_data addr=%h got=%h required=%h", a, got, exp_d);
        end
        checks++;
        if (srd !== !exp_hit || swr !== 1'b0) begin
            failures++; $display("FAIL load_enables addr=%h saw_rd=%b saw_wr=%b required rd=%b wr=0", a, srd, swr, !exp_hit);
        end
        if (exp_hit) m_touch(a);
        else         m_insert(a);
    endtask

    task automatic store_and_check(input logic [31:0] a, input logic [31:0] d, input bit also_rd, output int waits);
        bit exp_hit, srd, swr;
        logic [31:0] got;
        exp_hit = m_hit(a);
        do_access(also_rd, 1'b1, a, d, waits, got, srd, swr);
        checks++;
        if (swr !== 1'b1 || srd !== 1'b0) begin
            failures++; $display("FAIL store_enables addr=%h saw_wr=%b saw_rd=%b required 1,0", a, swr, srd);
        end
        checks++;
        if (waits < 1) begin
            failures++; $display("FAIL store_wait addr=%h waits=%0d required >=1", a, waits);
        end
        ref_mem[a >> 2] = d;
        if (exp_hit) m_touch(a);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (ready !== 1'b1 || rdata !== 32'h0 || sram_rd_en !== 1'b0 || sram_wr_en !== 1'b0) begin
            failures++; $display("FAIL reset_state ready=%b rdata=%h rd_en=%b wr_en=%b required 1,0,0,0", ready, rdata, sram_rd_en, sram_wr_en);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_first_miss();
        logic [31:0] got; bit hit;
        load_and_check(32'd1024, got, hit);
        checks++;
        if (got !== 32'hAAAA0000 || hit) begin
            failures++; $display("FAIL first_miss got=%h hit=%b required AAAA0000 miss", got, hit);
        end
        load_and_check(32'd1028, got, hit);
        checks++;
        if (got !== 32'hBBBB0001 || !hit) begin
            failures++; $display("FAIL block_word1 got=%h hit=%b required BBBB0001 hit", got, hit);
        end
    endtask

    task automatic test_lru_evict();
        logic [31:0] got; bit hit;
        bit exp [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [31:0] seq [5] = '{32'd1024, 32'd1536, 32'd2048, 32'd1536, 32'd1024};
        for (int i = 0; i < 5; i++) begin
            load_and_check(seq[i], got, hit);
            checks++;
            if (hit !== exp[i]) begin
                failures++; $display("FAIL lru_seq step=%0d addr=%h hit=%b required=%b", i, seq[i], hit, exp[i]);
            end
        end
        // 2048 (tag 2) must have been the one evicted by the final 1024 fill
        load_and_check(32'd2048, got, hit);
        checks++;
        if (hit !== 1'b0) begin
            failures++; $display("FAIL lru_evicted addr=2048 hit=%b required 0", hit);
        end
    endtask

    task automatic test_store_hit();
        logic [31:0] got; bit hit; int waits;
        load_and_check(32'd1024, got, hit);
        store_and_check(32'd1028, 32'h12345678, 1'b0, waits);
        checks++;
        if (waits != 2) begin
            failures++; $display("FAIL store_hit_waits waits=%0d required 2", waits);
        end
        load_and_check(32'd1028, got, hit);
        checks++;
        if (got !== 32'h12345678 || !hit) begin
            failures++; $display("FAIL store_hit_reload got=%h hit=%b required 12345678 hit", got, hit);
        end
    endtask

    task automatic test_store_miss();
        logic [31:0] got; bit hit; int waits;
        store_and_check(32'd4096, 32'hCAFE_F00D, 1'b0, waits);
        checks++;
        if (sram_word(32'd4096 >> 2) !== 32'hCAFE_F00D) begin
            failures++; $display("FAIL store_miss_sram got=%h required CAFEF00D", sram_word(32'd4096 >> 2));
        end
        load_and_check(32'd4096, got, hit);
        checks++;
        if (got !== 32'hCAFE_F00D || hit) begin
            failures++; $display("FAIL store_miss_reload got=%h hit=%b required CAFEF00D miss", got, hit);
        end
    endtask

    task automatic test_rw_both();
        int waits;
        store_and_check(32'd1024, 32'h0BAD_BEEF, 1'b1, waits);
        checks++;
        if (sram_word(32'd1024 >> 2) !== 32'h0BAD_BEEF) begin
            failures++; $display("FAIL rw_both_sram got=%h required 0BADBEEF", sram_word(32'd1024 >> 2));
        end
    endtask

    task automatic test_random();
        logic [31:0] a, got; bit hit; int waits, r;
        sram_lat = -1;
        for (int i = 0; i < 250; i++) begin
            a = 32'd1024 + ($urandom_range(0, 3) << 9) + ($urandom_range(0, 3) << 3) + ($urandom_range(0, 1) << 2);
            r = int'($urandom_range(0, 99));
            if (r < 70)      load_and_check(a, got, hit);
            else if (r < 95) store_and_check(a, $urandom, 1'b0, waits);
            else             store_and_check(a, $urandom, 1'b1, waits);
        end
        sram_lat = 0;
    endtask

    task automatic test_reset_mid();
        logic [31:0] got; bit hit;
        sram_lat = 10;
        mem_r_en = 1'b1; address = 32'h0000_8000;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (sram_rd_en !== 1'b1) begin
            failures++; $display("FAIL reset_mid_pending rd_en=%b required 1", sram_rd_en);
        end
        rst = 1'b1; mem_r_en = 1'b0;
        #1;
        checks++;
        if (sram_rd_en !== 1'b0 || sram_wr_en !== 1'b0 || ready !== 1'b1 || rdata !== 32'h0) begin
            failures++; $display("FAIL reset_mid rd_en=%b wr_en=%b ready=%b rdata=%h required 0,0,1,0", sram_rd_en, sram_wr_en, ready, rdata);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        m_reset();
        repeat (14) @(posedge clk);
        #1;
        sram_lat = 0;
        load_and_check(32'd1028, got, hit);
        checks++;
        if (hit !== 1'b0) begin
            failures++; $display("FAIL reset_invalidate addr=1028 hit=%b required 0", hit);
        end
    endtask

    initial begin
        rst = 1'b1; address = 32'h0; wdata = 32'h0; mem_r_en = 1'b0; mem_w_en = 1'b0;
        m_reset();
        sram_mem[256] = 32'hAAAA0000; sram_mem[257] = 32'hBBBB0001;
        ref_mem[256]  = 32'hAAAA0000; ref_mem[257]  = 32'hBBBB0001;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset();
        test_first_miss();
        test_lru_evict();
        test_store_hit();
        test_store_miss();
        test_rw_both();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
